fb_text_writer: RTL and testbench

- Upstream producer for the VGA text path. Accepts a byte stream of glyph codes and control characters over a valid/ready handshake.
- Writes the codes into the character frame buffer: 80 columns x 60 rows, two 8-bit glyph codes per 16-bit word, 40 words per row, starting at FB_BASE.
- Owns the text cursor. Performs read-modify-write of packed words, line wrap, scrolling and full-screen clear through a single-port synchronous RAM interface.

---
 rtl/fb_pkg.sv | 43 ++++
 rtl/fb_text_writer_if.sv | 23 ++
 rtl/fb_cell_addr.sv | 21 ++
 rtl/fb_text_writer.sv | 258 +++++++++++++++++++++++++
 tb/tb_fb_text_writer.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// Shared frame-buffer constants, control codes and writer state encoding.
// The scroll states exist only when FB_WRITER_SCROLL_EN is defined.
package fb_pkg;

  localparam int unsigned ADDR_W        = 16;
  localparam logic [15:0] FB_BASE       = 16'h3000;
  localparam int unsigned COLS          = 80;
  localparam int unsigned ROWS          = 60;
  localparam int unsigned WORDS_PER_ROW = 40;
  localparam int unsigned FB_WORDS      = 2400;
  localparam int unsigned IDX_W         = 12;
  localparam logic [7:0]  BLANK_GLYPH   = 8'h00;

  localparam logic [7:0] CH_NL = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_FF = 8'h0C;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD,
    S_RW,
    S_WR,
    S_ADV,
    S_CLR
`ifdef FB_WRITER_SCROLL_EN
    ,
    S_SCR_RD,
    S_SCR_RW,
    S_SCR_WR,
    S_SCR_FILL
`endif
  } state_e;

  // Cursor update applied in the ADV state.
  typedef enum logic [1:0] {
    OP_NONE,
    OP_INC,
    OP_NL,
    OP_CR
  } adv_op_e;

endpackage

// File: rtl/fb_text_writer_if.sv
// Character stream handshake plus single-port frame-buffer RAM bus.
// master = the text writer, slave = producer/RAM side.
interface fb_text_writer_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  logic [7:0]            char_in;
  logic                  char_valid;
  logic                  char_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_wdata;
  logic                  mem_we;
  logic [15:0]           mem_rdata;

  modport master (
    input  char_in, char_valid, mem_rdata,
    output char_ready, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    output char_in, char_valid, mem_rdata,
    input  char_ready, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/fb_cell_addr.sv
// Combinational (row, col) -> frame-buffer word address and byte lane.
// Row stride is a fixed 40 words, built as (row<<5)+(row<<3).
module fb_cell_addr #(
  parameter int unsigned          ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE      = 16'h3000
) (
  input  logic [5:0]            row_i,
  input  logic [6:0]            col_i,
  output logic [ADDR_WIDTH-1:0] addr_c_o,
  output logic                  hi_sel_c_o
);

  logic [ADDR_WIDTH-1:0] row_off_c;

  always_comb begin
    row_off_c  = (ADDR_WIDTH'(row_i) << 5) + (ADDR_WIDTH'(row_i) << 3);
    addr_c_o   = BASE + row_off_c + ADDR_WIDTH'(col_i[6:1]);
    hi_sel_c_o = ~col_i[0];
  end

endmodule

// File: rtl/fb_text_writer.sv
// Byte-stream text writer: packs glyphs into the character frame buffer,
// owns the cursor, handles wrap/backspace/clear. Scroll via FB_WRITER_SCROLL_EN.
module fb_text_writer #(
  parameter int unsigned           ADDR_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] FB_BASE     = ADDR_WIDTH'(fb_pkg::FB_BASE),
  parameter int unsigned           COLS        = fb_pkg::COLS,
  parameter int unsigned           ROWS        = fb_pkg::ROWS,
  parameter logic [7:0]            BLANK_GLYPH = fb_pkg::BLANK_GLYPH
) (
  input  logic                 clk,
  input  logic                 reset,
  fb_text_writer_if.master     bus,
  output logic [6:0]           cursor_col,
  output logic [5:0]           cursor_row,
  output logic                 busy
);
  import fb_pkg::*;

  localparam int unsigned       ROW_WORDS = COLS / 2;
  localparam int unsigned       CNT_W     = 12;
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(ROWS * ROW_WORDS - 1);
  localparam logic [6:0]        LAST_COL  = 7'(COLS - 1);
  localparam logic [5:0]        LAST_ROW  = 6'(ROWS - 1);
`ifdef FB_WRITER_SCROLL_EN
  localparam logic [CNT_W-1:0]  LAST_COPY = CNT_W'((ROWS - 1) * ROW_WORDS - 1);
`endif

  state_e                state_q, state_d;
  adv_op_e               op_q, op_d;
  logic [6:0]            col_q, col_d;
  logic [5:0]            row_q, row_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic [CNT_W-1:0]      idx_q, idx_d;
  logic [7:0]            glyph_q, glyph_d;
  logic                  hi_q, hi_d;

  logic [6:0]            back_col_c, cell_col_c;
  logic [5:0]            back_row_c, cell_row_c;
  logic [ADDR_WIDTH-1:0] cell_addr_c;
  logic                  cell_hi_c;
  logic                  adv_row_c;

  // Backspace addresses the cell before the cursor; everything else the cursor.
  always_comb begin
    back_col_c = (col_q == 7'd0) ? LAST_COL : col_q - 7'd1;
    back_row_c = (col_q == 7'd0) ? row_q - 6'd1 : row_q;
    cell_col_c = (bus.char_in == CH_BS) ? back_col_c : col_q;
    cell_row_c = (bus.char_in == CH_BS) ? back_row_c : row_q;
  end

  fb_cell_addr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE       (FB_BASE)
  ) u_cell_addr (
    .row_i      (cell_row_c),
    .col_i      (cell_col_c),
    .addr_c_o   (cell_addr_c),
    .hi_sel_c_o (cell_hi_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    col_d     = col_q;
    row_d     = row_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    idx_d     = idx_q;
    glyph_d   = glyph_q;
    hi_d      = hi_q;
    adv_row_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.char_valid && ready_q) begin
          case (bus.char_in)
            CH_NL: begin
              op_d    = OP_NL;
              state_d = S_ADV;
            end
            CH_CR: begin
              op_d    = OP_CR;
              state_d = S_ADV;
            end
            CH_BS: begin
              op_d = OP_NONE;
              if (col_q == 7'd0 && row_q == 6'd0) begin
                state_d = S_ADV;
              end else begin
                col_d   = back_col_c;
                row_d   = back_row_c;
                addr_d  = cell_addr_c;
                hi_d    = cell_hi_c;
                glyph_d = BLANK_GLYPH;
                state_d = S_RD;
              end
            end
            CH_FF: begin
              addr_d  = FB_BASE;
              wdata_d = {BLANK_GLYPH, BLANK_GLYPH};
              we_d    = 1'b1;
              idx_d   = '0;
              state_d = S_CLR;
            end
            default: begin
              addr_d  = cell_addr_c;
              hi_d    = cell_hi_c;
              glyph_d = bus.char_in;
              op_d    = OP_INC;
              state_d = S_RD;
            end
          endcase
        end
      end

      S_RD: state_d = S_RW;

      S_RW: begin
        wdata_d = hi_q ? {glyph_q, bus.mem_rdata[7:0]} : {bus.mem_rdata[15:8], glyph_q};
        we_d    = 1'b1;
        state_d = S_WR;
      end

      S_WR: state_d = S_ADV;

      S_ADV: begin
        state_d = S_IDLE;
        case (op_q)
          OP_NL: begin
            col_d     = 7'd0;
            adv_row_c = 1'b1;
          end
          OP_CR: col_d = 7'd0;
          OP_INC: begin
            if (col_q == LAST_COL) begin
              col_d     = 7'd0;
              adv_row_c = 1'b1;
            end else begin
              col_d = col_q + 7'd1;
            end
          end
          default: ;
        endcase
        if (adv_row_c) begin
          if (row_q != LAST_ROW) begin
            row_d = row_q + 6'd1;
          end else begin
`ifdef FB_WRITER_SCROLL_EN
            addr_d  = FB_BASE + ADDR_WIDTH'(ROW_WORDS);
            idx_d   = '0;
            state_d = S_SCR_RD;
`else
            row_d = 6'd0;
`endif
          end
        end
      end

      S_CLR: begin
        if (idx_q == LAST_WORD) begin
          col_d   = 7'd0;
          row_d   = 6'd0;
          state_d = S_IDLE;
        end else begin
          idx_d  = idx_q + CNT_W'(1);
          addr_d = addr_q + ADDR_WIDTH'(1);
          we_d   = 1'b1;
        end
      end

`ifdef FB_WRITER_SCROLL_EN
      S_SCR_RD: state_d = S_SCR_RW;

      S_SCR_RW: begin
        wdata_d = bus.mem_rdata;
        addr_d  = FB_BASE + ADDR_WIDTH'(idx_q);
        we_d    = 1'b1;
        state_d = S_SCR_WR;
      end

      // After the last copy the bottom row is blanked in one word per cycle.
      S_SCR_WR: begin
        idx_d = idx_q + CNT_W'(1);
        if (idx_q == LAST_COPY) begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          wdata_d = {BLANK_GLYPH, BLANK_GLYPH};
          we_d    = 1'b1;
          state_d = S_SCR_FILL;
        end else begin
          addr_d  = addr_q + ADDR_WIDTH'(ROW_WORDS + 1);
          state_d = S_SCR_RD;
        end
      end

      S_SCR_FILL: begin
        if (idx_q == LAST_WORD) begin
          state_d = S_IDLE;
        end else begin
          idx_d  = idx_q + CNT_W'(1);
          addr_d = addr_q + ADDR_WIDTH'(1);
          we_d   = 1'b1;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = ~ready_d;
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_NONE;
      col_q   <= 7'd0;
      row_q   <= 6'd0;
      addr_q  <= FB_BASE;
      wdata_q <= 16'h0000;
      we_q    <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      idx_q   <= '0;
      glyph_q <= 8'h00;
      hi_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      idx_q   <= idx_d;
      glyph_q <= glyph_d;
      hi_q    <= hi_d;
    end
  end

  assign bus.char_ready = ready_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_we     = we_q;
  assign cursor_col     = col_q;
  assign cursor_row     = row_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_fb_text_writer.sv
// Scoreboard bench for fb_text_writer: a behavioural cursor/memory model pushes
// expected writes, a negedge monitor pops and compares every DUT write.
module tb_fb_text_writer;
  import fb_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] cursor_col;
  logic [5:0] cursor_row;
  logic       busy;

  fb_text_writer_if #(.ADDR_WIDTH(16)) fb_if ();

  fb_text_writer #(.ADDR_WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (fb_if.master),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  logic [15:0] ram     [0:65535];
  logic [15:0] exp_mem [0:65535];

  always @(posedge clk) begin
    if (fb_if.mem_we) ram[fb_if.mem_addr] <= fb_if.mem_wdata;
    fb_if.mem_rdata <= ram[fb_if.mem_addr];
  end

  int          n_cmp = 0;
  int          n_err = 0;
  int          wr_cnt = 0;
  bit          sb_en = 1'b1;
  logic [31:0] exp_q [$];
  logic [31:0] sb_e;
  int          m_col = 0;
  int          m_row = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every write strobe is matched against the head of the expected queue.
  always @(negedge clk) begin
    if (!reset && fb_if.mem_we === 1'b1) begin
      wr_cnt = wr_cnt + 1;
      if (sb_en) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow_addr", 32'(fb_if.mem_addr), 32'hFFFF_FFFF);
        end else begin
          sb_e = exp_q.pop_front();
          check("wr_addr", 32'(fb_if.mem_addr), 32'(sb_e[31:16]));
          check("wr_data", 32'(fb_if.mem_wdata), 32'(sb_e[15:0]));
        end
      end
    end
  end

  task automatic push_wr(input logic [15:0] a, input logic [15:0] d);
    exp_q.push_back({a, d});
    exp_mem[a] = d;
  endtask

  task automatic model_rmw(input logic [7:0] g);
    logic [15:0] a;
    logic [15:0] old;
    a   = 16'(16'h3000 + m_row * 40 + m_col / 2);
    old = exp_mem[a];
    if (m_col % 2 == 0) push_wr(a, {g, old[7:0]});
    else                push_wr(a, {old[15:8], g});
  endtask

  task automatic model_row_adv();
    if (m_row < 59) begin
      m_row = m_row + 1;
    end else begin
`ifdef FB_WRITER_SCROLL_EN
      for (int i = 0; i < 2360; i++) push_wr(16'(16'h3000 + i), exp_mem[16'(16'h3028 + i)]);
      for (int i = 2360; i < 2400; i++) push_wr(16'(16'h3000 + i), 16'h0000);
`else
      m_row = 0;
`endif
    end
  endtask

  task automatic model_char(input logic [7:0] c);
    case (c)
      8'h0A: begin m_col = 0; model_row_adv(); end
      8'h0D: m_col = 0;
      8'h08: begin
        if (!(m_col == 0 && m_row == 0)) begin
          if (m_col == 0) begin m_col = 79; m_row = m_row - 1; end
          else m_col = m_col - 1;
          model_rmw(8'h00);
        end
      end
      8'h0C: begin
        for (int i = 0; i < 2400; i++) push_wr(16'(16'h3000 + i), 16'h0000);
        m_col = 0;
        m_row = 0;
      end
      default: begin
        model_rmw(c);
        m_col = m_col + 1;
        if (m_col == 80) begin m_col = 0; model_row_adv(); end
      end
    endcase
  endtask

  // Drive one byte and return how many sampled cycles char_ready stayed low.
  task automatic send_char(input logic [7:0] c, output int lo_cycles);
    int  t;
    bit  done;
    model_char(c);
    @(negedge clk);
    t = 0;
    while (!fb_if.char_ready && t < 1000) begin @(negedge clk); t++; end
    if (!fb_if.char_ready) check("ready_timeout", 32'(fb_if.char_ready), 32'd1);
    fb_if.char_in    = c;
    fb_if.char_valid = 1'b1;
    @(posedge clk);
    #1;
    fb_if.char_valid = 1'b0;
    fb_if.char_in    = 8'($urandom);
    lo_cycles = 0;
    done      = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (fb_if.char_ready) done = 1'b1;
      else begin
        lo_cycles++;
        if (lo_cycles > 20000) begin
          check("busy_timeout", 32'(fb_if.char_ready), 32'd1);
          done = 1'b1;
        end
      end
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lo;
    int w0;
    int t;
    logic [15:0] v;

    for (int a = 0; a < 65536; a++) begin
      v = (a >= 16'h3028 && a < 16'h3960) ? (16'(a) ^ 16'hA5C3) : 16'hFFFF;
      ram[a]     = v;
      exp_mem[a] = v;
    end
    fb_if.char_in    = 8'h00;
    fb_if.char_valid = 1'b0;
    reset            = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(fb_if.char_ready), 32'd1);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_we",    32'(fb_if.mem_we), 32'd0);
    check("rst_addr",  32'(fb_if.mem_addr), 32'h3000);
    check("rst_wdata", 32'(fb_if.mem_wdata), 32'h0000);
    check("rst_col",   32'(cursor_col), 32'd0);
    check("rst_row",   32'(cursor_row), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Two glyphs packed into the first word.
    send_char(8'h41, lo);
    check("lo_cycles_41", 32'(lo), 32'd4);
    send_char(8'h42, lo);
    check("lo_cycles_42", 32'(lo), 32'd4);
    check("col_after_AB", 32'(cursor_col), 32'd2);
    check("ram_3000", 32'(ram[16'h3000]), 32'h4142);

    // Fill to the last column, then wrap.
    for (int i = 0; i < 77; i++) send_char(8'(8'h61 + i % 26), lo);
    check("col_79", 32'(cursor_col), 32'd79);
    check("row_0",  32'(cursor_row), 32'd0);
    send_char(8'h43, lo);
    check("wrap_col", 32'(cursor_col), 32'd0);
    check("wrap_row", 32'(cursor_row), 32'd1);
    check("ram_3027_lo", 32'(ram[16'h3027][7:0]), 32'h43);

    // Backspace across a row boundary.
    send_char(8'h0A, lo);
    check("nl_row", 32'(cursor_row), 32'd2);
    send_char(8'h08, lo);
    check("bs_col", 32'(cursor_col), 32'd79);
    check("bs_row", 32'(cursor_row), 32'd1);
    check("ram_304F", 32'(ram[16'h304F]), 32'h9500);

    // Carriage return touches only the column.
    send_char(8'h78, lo);
    send_char(8'h79, lo);
    send_char(8'h0D, lo);
    check("lo_cycles_cr", 32'(lo), 32'd1);
    check("cr_col", 32'(cursor_col), 32'd0);
    check("cr_row", 32'(cursor_row), 32'd2);

    // Walk down to the bottom row, then advance past it.
    for (int i = 0; i < 57; i++) send_char(8'h0A, lo);
    check("bottom_row", 32'(cursor_row), 32'd59);
    w0 = wr_cnt;
    send_char(8'h0A, lo);
`ifdef FB_WRITER_SCROLL_EN
    check("scroll_writes", 32'(wr_cnt - w0), 32'd2400);
    check("scroll_row", 32'(cursor_row), 32'd59);
    check("scroll_fill_last", 32'(ram[16'h395F]), 32'h0000);
`else
    check("wrap_writes", 32'(wr_cnt - w0), 32'd0);
    check("wrap_row0", 32'(cursor_row), 32'd0);
`endif
    check("nl_col", 32'(cursor_col), 32'd0);

    // Full-screen clear.
    send_char(8'h5A, lo);
    w0 = wr_cnt;
    send_char(8'h0C, lo);
    check("clr_writes", 32'(wr_cnt - w0), 32'd2400);
    check("clr_col", 32'(cursor_col), 32'd0);
    check("clr_row", 32'(cursor_row), 32'd0);
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_ram_3000", 32'(ram[16'h3000]), 32'h0000);

    // Backspace at home writes nothing.
    w0 = wr_cnt;
    send_char(8'h08, lo);
    check("bs_home_writes", 32'(wr_cnt - w0), 32'd0);
    check("bs_home_col", 32'(cursor_col), 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a clear.
    sb_en = 1'b0;
    @(negedge clk);
    fb_if.char_in    = 8'h0C;
    fb_if.char_valid = 1'b1;
    @(posedge clk);
    #1;
    fb_if.char_valid = 1'b0;
    w0 = wr_cnt;
    t  = 0;
    while ((wr_cnt - w0) < 100 && t < 3000) begin @(negedge clk); #1; t++; end
    check("clr_reached_100", 32'(wr_cnt - w0), 32'd100);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_we",    32'(fb_if.mem_we), 32'd0);
    check("abort_ready", 32'(fb_if.char_ready), 32'd1);
    check("abort_col",   32'(cursor_col), 32'd0);
    check("abort_row",   32'(cursor_row), 32'd0);
    check("abort_busy",  32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    w0 = wr_cnt;
    repeat (50) @(negedge clk);
    check("abort_no_writes", 32'(wr_cnt - w0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
